// File: rtl/synapse_accumulator.sv
// Weighted spike accumulator feeding one LIF neuron: two-stage lookup/add pipe, flushes on each timestep pulse.
// Timestep at T gives cur_valid at T+2; a held output stalls the flush, which drops spike_ready until the neuron takes it.
module synapse_accumulator #(
  parameter int NUM_INPUTS   = 16,
  parameter int IDX_WIDTH    = $clog2(NUM_INPUTS),
  parameter int WEIGHT_WIDTH = 32,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    spike_valid,
  input  logic [IDX_WIDTH-1:0]    spike_idx,
  output logic                    spike_ready,
  input  logic                    wr_en,
  input  logic [IDX_WIDTH-1:0]    wr_addr,
  input  logic [WEIGHT_WIDTH-1:0] wr_data,
  input  logic                    timestep,
  output logic                    cur_valid,
  output logic [ACC_WIDTH-1:0]    cur_data,
  output logic                    cur_sat,
  input  logic                    cur_ready,
  output logic                    ts_overrun
);

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t                         state;
  logic signed [WEIGHT_WIDTH-1:0] weights [NUM_INPUTS];
  logic        [ACC_WIDTH-1:0]    acc;
  logic        [ACC_WIDTH-1:0]    pipe_w;
  logic                           pipe_valid;
  logic                           sat_flag;

  logic                           idx_ok;
  logic                           wr_ok;
  logic                           spike_accept;
  logic                           out_free;
  logic        [ACC_WIDTH-1:0]    rd_w;
  logic        [ACC_WIDTH-1:0]    add_in;
  logic        [ACC_WIDTH-1:0]    sum_val;
  logic                           sum_clamp;

  // Returns {clamped, value}; the sum is formed one bit wider so overflow shows as a sign disagreement.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  generate
    if (NUM_INPUTS < (1 << IDX_WIDTH)) begin : g_partial_range
      assign idx_ok = (32'(spike_idx) < NUM_INPUTS);
      assign wr_ok  = (32'(wr_addr) < NUM_INPUTS);
    end else begin : g_full_range
      assign idx_ok = 1'b1;
      assign wr_ok  = 1'b1;
    end
  endgenerate

  assign spike_ready  = rst_n && (state == ACCUM);
  assign spike_accept = spike_valid && spike_ready;
  assign out_free     = !cur_valid || cur_ready;

  always_comb begin
    rd_w   = idx_ok ? ACC_WIDTH'(weights[spike_idx]) : '0;
    add_in = pipe_valid ? pipe_w : '0;
    {sum_clamp, sum_val} = sat_add(acc, add_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INPUTS; i++) weights[i] <= '0;
      state      <= ACCUM;
      acc        <= '0;
      pipe_w     <= '0;
      pipe_valid <= 1'b0;
      sat_flag   <= 1'b0;
      cur_valid  <= 1'b0;
      cur_data   <= '0;
      cur_sat    <= 1'b0;
      ts_overrun <= 1'b0;
    end else begin
      // Reads above see the pre-edge array, so a same-cycle write is not forwarded.
      if (wr_en && wr_ok) weights[wr_addr] <= wr_data;

      if (cur_valid && cur_ready) cur_valid <= 1'b0;

      case (state)
        ACCUM: begin
          pipe_valid <= spike_accept;
          if (spike_accept) pipe_w <= rd_w;
          acc      <= sum_val;
          sat_flag <= sat_flag | sum_clamp;
          if (timestep) state <= FLUSH;
        end
        FLUSH: begin
          if (timestep) ts_overrun <= 1'b1;
          if (out_free) begin
            cur_data   <= sum_val;
            cur_sat    <= sat_flag | sum_clamp;
            cur_valid  <= 1'b1;
            acc        <= '0;
            sat_flag   <= 1'b0;
            pipe_valid <= 1'b0;
            state      <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Bench for synapse_accumulator: vector table plus hand sequences, outputs checked through an in-order queue.
module tb_synapse_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        spike_valid = 1'b0;
  logic [3:0]  spike_idx = '0;
  logic        spike_ready;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        timestep = 1'b0;
  logic        cur_valid;
  logic [31:0] cur_data;
  logic        cur_sat;
  logic        cur_ready = 1'b1;
  logic        ts_overrun;

  synapse_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_ready(spike_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .timestep(timestep),
    .cur_valid(cur_valid), .cur_data(cur_data), .cur_sat(cur_sat), .cur_ready(cur_ready),
    .ts_overrun(ts_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
  } exp_t;

  typedef struct {
    int          n;
    logic [15:0] idxs;
    logic [31:0] data;
    logic        sat;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cur_valid && cur_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", cur_data, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_cur_data", cur_data, e.data);
        check("sb_cur_sat", 32'(cur_sat), 32'(e.sat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!spike_ready && n < 50) begin
      tick();
      n++;
    end
    if (!spike_ready) check("spike_ready_timeout", 32'(spike_ready), 32'd1);
  endtask

  task automatic spike(input logic [3:0] idx);
    wait_ready();
    spike_valid = 1'b1;
    spike_idx   = idx;
    tick();
    spike_valid = 1'b0;
  endtask

  task automatic ts(input logic [31:0] data, input logic sat);
    exp_q.push_back('{data: data, sat: sat});
    timestep = 1'b1;
    tick();
    timestep = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 4, idxs: 16'h3550, data: 32'h0000_8000, sat: 1'b0};
    vecs[1] = '{n: 0, idxs: 16'h0000, data: 32'h0000_0000, sat: 1'b0};
    vecs[2] = '{n: 1, idxs: 16'h0000, data: 32'h0000_0100, sat: 1'b0};
    vecs[3] = '{n: 2, idxs: 16'h0011, data: 32'h7FFF_FFFF, sat: 1'b1};
    vecs[4] = '{n: 2, idxs: 16'h0022, data: 32'h8000_0000, sat: 1'b1};
    vecs[5] = '{n: 2, idxs: 16'h0035, data: 32'h0000_3F00, sat: 1'b0};
    vecs[6] = '{n: 3, idxs: 16'h0021, data: 32'h0000_00FF, sat: 1'b0};
    vecs[7] = '{n: 3, idxs: 16'h0311, data: 32'h7FFF_FEFF, sat: 1'b1};
    vecs[8] = '{n: 2, idxs: 16'h000F, data: 32'h0000_0100, sat: 1'b0};

    #3 rst_n = 1'b0;
    tick();
    check("rst_spike_ready", 32'(spike_ready), 32'd0);
    check("rst_cur_valid", 32'(cur_valid), 32'd0);
    check("rst_cur_data", cur_data, 32'd0);
    check("rst_cur_sat", 32'(cur_sat), 32'd0);
    check("rst_ts_overrun", 32'(ts_overrun), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_spike_ready", 32'(spike_ready), 32'd1);

    wr(4'd0, 32'h0000_0100);
    wr(4'd3, 32'hFFFF_FF00);
    wr(4'd5, 32'h0000_4000);
    wr(4'd1, 32'h7FFF_FFFF);
    wr(4'd2, 32'h8000_0000);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vecs[i].n; k++) spike(vecs[i].idxs[4*k +: 4]);
      wait_ready();
      ts(vecs[i].data, vecs[i].sat);
      if (i == 0) begin
        check("latency_t1_not_valid", 32'(cur_valid), 32'd0);
        tick();
        check("latency_t2_valid", 32'(cur_valid), 32'd1);
      end
    end
    drain();

    // Backpressure: A and B both held, third pulse lands in FLUSH and is dropped.
    cur_ready = 1'b0;
    spike(4'd0);
    ts(32'h0000_0100, 1'b0);
    spike(4'd5);
    spike(4'd5);
    ts(32'h0000_8000, 1'b0);
    tick();
    tick();
    check("bp_spike_ready_low", 32'(spike_ready), 32'd0);
    check("bp_held_valid", 32'(cur_valid), 32'd1);
    check("bp_held_data", cur_data, 32'h0000_0100);
    check("bp_overrun_before", 32'(ts_overrun), 32'd0);
    timestep = 1'b1;
    tick();
    timestep = 1'b0;
    check("bp_overrun_set", 32'(ts_overrun), 32'd1);
    cur_ready = 1'b1;
    drain();
    check("bp_overrun_sticky", 32'(ts_overrun), 32'd1);

    // Same-cycle write returns old weight; spike with the pulse joins the ending sum.
    wait_ready();
    spike_valid = 1'b1;
    spike_idx   = 4'd0;
    wr_en       = 1'b1;
    wr_addr     = 4'd0;
    wr_data     = 32'h0000_0200;
    tick();
    wr_en = 1'b0;
    exp_q.push_back('{data: 32'h0000_0300, sat: 1'b0});
    timestep = 1'b1;
    tick();
    spike_valid = 1'b0;
    timestep    = 1'b0;
    spike(4'd0);
    wait_ready();
    ts(32'h0000_0200, 1'b0);
    drain();

    // Reset while FLUSH is stalled behind a held output.
    cur_ready = 1'b0;
    spike(4'd0);
    wait_ready();
    timestep = 1'b1;
    tick();
    timestep = 1'b0;
    spike(4'd0);
    timestep = 1'b1;
    tick();
    timestep = 1'b0;
    tick();
    check("pre_rst_flush_stall", 32'(spike_ready), 32'd0);
    check("pre_rst_valid", 32'(cur_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cur_valid", 32'(cur_valid), 32'd0);
    check("mid_rst_cur_data", cur_data, 32'd0);
    check("mid_rst_overrun", 32'(ts_overrun), 32'd0);
    tick();
    rst_n     = 1'b1;
    cur_ready = 1'b1;
    tick();
    spike(4'd0);
    wait_ready();
    ts(32'h0000_0000, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
